audio_pwm_dac: RTL and testbench

AUDIO_PWM_DAC -- requirements
Module: audio_pwm_dac

---
 rtl/audio_pwm_dac.sv | 96 +++++++++
 tb/tb_audio_pwm_dac.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_dac.sv
// PWM audio DAC: volume-scaled sample drives a free-running PWM counter,
// with a halving fade-out before going idle when sound is disabled.
module audio_pwm_dac #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] dacCount_i,
  input  logic             enable_i,
  input  logic [1:0]       volume_i,
  output logic             pwm_o,
  output logic             periodStart_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FADE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] scaled;
  logic [CNT_W-1:0] duty_half;
  logic             cnt_last;

  assign scaled    = dacCount_i >> (2'd3 - volume_i);
  assign duty_half = duty_q >> 1;
  assign cnt_last  = &cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
    end
  end

  // Duty only ever changes on the last count of a period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        duty_d = '0;
        if (enable_i) begin
          state_d = RUN;
          duty_d  = scaled;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (!enable_i) begin
          state_d = FADE;
        end else if (cnt_last) begin
          duty_d = scaled;
        end
      end
      FADE: begin
        cnt_d = cnt_q + 1'b1;
        if (enable_i) begin
          state_d = RUN;
          if (cnt_last) begin
            duty_d = scaled;
          end
        end else if (cnt_last) begin
          if (duty_half == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
            duty_d  = '0;
          end else begin
            duty_d = duty_half;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        duty_d  = '0;
      end
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign pwm_o         = busy_o && (cnt_q < duty_q);
  assign periodStart_o = busy_o && (cnt_q == '0);

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Bench for audio_pwm_dac: per-cycle check against a period-level model,
// plus literal high-count expectations per PWM period.
module tb_audio_pwm_dac;

  localparam int PER = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dac;
  logic       en;
  logic [1:0] vol;
  logic       pwm, ps, busy;

  int vectors = 0;
  int errs    = 0;
  bit chk_on  = 1'b0;

  audio_pwm_dac #(.CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .dacCount_i    (dac),
    .enable_i      (en),
    .volume_i      (vol),
    .pwm_o         (pwm),
    .periodStart_o (ps),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Model: mode 0 silent, 1 playing, 2 fading; pos within period; level = duty.
  int m_mode = 0;
  int m_pos  = 0;
  int m_lvl  = 0;

  always @(posedge clk or posedge rst) begin : model
    int s, nm, np, nl;
    if (rst) begin
      m_mode <= 0;
      m_pos  <= 0;
      m_lvl  <= 0;
    end else begin
      s  = int'(dac) / (1 << (3 - int'(vol)));
      nm = m_mode;
      np = (m_pos + 1) % PER;
      nl = m_lvl;
      if (m_mode == 0) begin
        np = 0;
        nl = 0;
        if (en) begin
          nm = 1;
          nl = s;
        end
      end else if (m_mode == 1) begin
        if (!en) nm = 2;
        else if (m_pos == PER - 1) nl = s;
      end else begin
        if (en) begin
          nm = 1;
          if (m_pos == PER - 1) nl = s;
        end else if (m_pos == PER - 1) begin
          nl = m_lvl / 2;
          if (nl == 0) begin
            nm = 0;
            np = 0;
          end
        end
      end
      m_mode <= nm;
      m_pos  <= np;
      m_lvl  <= nl;
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pwm", pwm, (m_mode != 0) && (m_pos < m_lvl));
      chk("periodStart", ps, (m_mode != 0) && (m_pos == 0));
      chk("busy", busy, m_mode != 0);
    end
  end

  // Count high cycles over one full period starting at a periodStart pulse.
  task automatic measure(input int exp, input bit skip, input string nm);
    int hi = 0;
    int guard = 0;
    if (skip) @(negedge clk);
    while (ps !== 1'b1 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) begin
      vectors++;
      errs++;
      $display("FAIL %s: no periodStart within 600 cycles", nm);
    end else begin
      for (int i = 0; i < PER; i++) begin
        if (pwm === 1'b1) hi++;
        @(negedge clk);
      end
      chk_int(nm, hi, exp);
    end
  endtask

  initial begin
    int hi;
    rst = 1'b1;
    en  = 1'b1;
    dac = 8'hFF;
    vol = 2'd3;
    @(posedge clk);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk_int("rst_outs", {29'd0, pwm, ps, busy}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_after_release", busy, 1'b1);

    measure(255, 1'b1, "duty_255");
    dac = 8'd0;
    measure(0, 1'b1, "duty_0");
    dac = 8'd64;
    measure(64, 1'b1, "duty_64");

    dac = 8'd200;
    vol = 2'd0;
    measure(25, 1'b1, "vol0");
    vol = 2'd1;
    measure(50, 1'b1, "vol1");
    vol = 2'd2;
    measure(100, 1'b1, "vol2");
    vol = 2'd3;
    measure(200, 1'b1, "vol3");

    dac = 8'd64;
    measure(64, 1'b1, "pre_mid");
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == 100) dac = 8'd128;
      if (pwm === 1'b1) hi++;
      @(negedge clk);
    end
    chk_int("mid_cur", hi, 64);
    measure(128, 1'b0, "mid_next");

    en = 1'b0;
    for (int k = 0; k < 8; k++) measure(128 >> k, 1'b0, "fade");
    chk("fade_idle_busy", busy, 1'b0);
    chk("fade_idle_pwm", pwm, 1'b0);

    en = 1'b1;
    measure(128, 1'b1, "restart");
    en = 1'b0;
    measure(128, 1'b0, "fade2_a");
    measure(64, 1'b0, "fade2_b");
    repeat (50) @(negedge clk);
    en = 1'b1;
    measure(128, 1'b1, "refire");

    repeat (37) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_pwm", pwm, 1'b0);
    chk("async_ps", ps, 1'b0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("stay_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
